// File: rtl/memory_writeback_if.sv
// memory_writeback_if: memory-stage-to-writeback bundle.
// slave = writeback stage (consumes stage inputs, drives writeback/forwarding outputs)
// master = memory stage / environment side.
interface memory_writeback_if #(parameter int COUNT_WIDTH = 32);
  logic                   stallInput;
  logic                   flushInput;
  logic                   validInput;
  logic                   memToRegInput;
  logic                   regWriteInput;
  logic [1:0]             loadSizeInput;
  logic                   loadSignedInput;
  logic [31:0]            aluResultInput;
  logic [31:0]            dataMemoryInput;
  logic [4:0]             regWriteAddressInput;
  logic                   validOutput;
  logic                   regWriteOutput;
  logic [4:0]             regWriteAddressOutput;
  logic [31:0]            regWriteDataOutput;
  logic                   misalignedOutput;
  logic [COUNT_WIDTH-1:0] retiredCountOutput;
  modport slave (
    input  stallInput, flushInput, validInput, memToRegInput, regWriteInput,
           loadSizeInput, loadSignedInput, aluResultInput, dataMemoryInput,
           regWriteAddressInput,
    output validOutput, regWriteOutput, regWriteAddressOutput, regWriteDataOutput,
           misalignedOutput, retiredCountOutput
  );
  modport master (
    output stallInput, flushInput, validInput, memToRegInput, regWriteInput,
           loadSizeInput, loadSignedInput, aluResultInput, dataMemoryInput,
           regWriteAddressInput,
    input  validOutput, regWriteOutput, regWriteAddressOutput, regWriteDataOutput,
           misalignedOutput, retiredCountOutput
  );
endinterface

// File: rtl/memory_writeback.sv
// memory_writeback: MEM/WB register with sub-word load extraction and qualified register write.
// Ports: clk, reset (async active-low), bus (memory_writeback_if.slave).
// Optional macro MEMORY_WRITEBACK_RETIRE_COUNTER_EN builds the retired-instruction counter;
// without it retiredCountOutput is constant 0.
module memory_writeback #(parameter int COUNT_WIDTH = 32) (
  input logic             clk,
  input logic             reset,
  memory_writeback_if.slave bus
);
  logic [1:0]  w_a;
  logic [31:0] w_dm;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_data;
  logic        w_mis;
  logic        w_we;
  logic        w_capture;
  logic        r_valid;
  logic        r_we;
  logic        r_mis;
  logic [4:0]  r_addr;
  logic [31:0] r_data;
  always_comb begin
    w_a = bus.aluResultInput[1:0];
    w_dm = bus.dataMemoryInput;
    w_byte = w_a[1] ? (w_a[0] ? w_dm[31:24] : w_dm[23:16]) : (w_a[0] ? w_dm[15:8] : w_dm[7:0]);
    w_half = w_a[1] ? w_dm[31:16] : w_dm[15:0];
    w_load = bus.loadSizeInput == 2'b01 ? {{16{bus.loadSignedInput & w_half[15]}}, w_half} :
             bus.loadSizeInput == 2'b10 ? {{24{bus.loadSignedInput & w_byte[7]}}, w_byte} : w_dm;
    w_data = bus.memToRegInput ? w_load : bus.aluResultInput;
    // bytes are never misaligned; size 11 is checked like a word
    w_mis = bus.memToRegInput & bus.validInput &
            (bus.loadSizeInput == 2'b01 ? w_a[0] : bus.loadSizeInput == 2'b10 ? 1'b0 : |w_a);
    w_we = bus.validInput & bus.regWriteInput & |bus.regWriteAddressInput & ~w_mis;
    w_capture = ~bus.flushInput & ~bus.stallInput;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset || bus.flushInput) begin
      r_valid <= 1'b0;
      r_we <= 1'b0;
      r_mis <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else if (!bus.stallInput) begin
      r_valid <= bus.validInput;
      r_we <= w_we;
      r_mis <= w_mis;
      r_addr <= bus.regWriteAddressInput;
      r_data <= w_data;
    end
  end
  assign bus.validOutput = r_valid;
  assign bus.regWriteOutput = r_we;
  assign bus.misalignedOutput = r_mis;
  assign bus.regWriteAddressOutput = r_addr;
  assign bus.regWriteDataOutput = r_data;
`ifdef MEMORY_WRITEBACK_RETIRE_COUNTER_EN
  logic [COUNT_WIDTH-1:0] r_count;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_count <= '0;
    else if (w_capture && bus.validInput) r_count <= r_count + COUNT_WIDTH'(1);
  end
  assign bus.retiredCountOutput = r_count;
`else
  logic w_unused;
  assign w_unused = w_capture;
  assign bus.retiredCountOutput = '0;
`endif
endmodule

// File: tb/tb_memory_writeback.sv
// tb_memory_writeback: randomized scoreboard bench for memory_writeback.
module tb_memory_writeback;
  localparam int CW = 4;
  typedef struct {
    logic        v, we, mis;
    logic [4:0]  a;
    logic [31:0] d;
    logic [CW-1:0] c;
  } exp_t;
  logic clk = 0;
  logic reset = 0;
  int total = 0;
  int bad = 0;
  exp_t q[$];
  exp_t m;
  memory_writeback_if #(.COUNT_WIDTH(CW)) bus();
  memory_writeback #(.COUNT_WIDTH(CW)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", n, got, exp);
    end
  endtask
  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, ".valid"}, 32'(bus.validOutput), 32'(e.v));
    chk({tag, ".regwrite"}, 32'(bus.regWriteOutput), 32'(e.we));
    chk({tag, ".misaligned"}, 32'(bus.misalignedOutput), 32'(e.mis));
    chk({tag, ".addr"}, 32'(bus.regWriteAddressOutput), 32'(e.a));
    chk({tag, ".data"}, bus.regWriteDataOutput, e.d);
    chk({tag, ".count"}, 32'(bus.retiredCountOutput), 32'(e.c));
  endtask
  function automatic logic [31:0] load_val(input logic [1:0] sz, input logic sg, input int unsigned a,
                                           input logic [31:0] dm);
    int unsigned b, h;
    b = (dm >> (8 * a)) & 32'hFF;
    h = (dm >> (16 * (a / 2))) & 32'hFFFF;
    if (sz == 2) return (sg && b >= 128) ? b - 256 : b;
    if (sz == 1) return (sg && h >= 32768) ? h - 65536 : h;
    return dm;
  endfunction
  task automatic step(input logic st, input logic fl, input logic v, input logic m2r, input logic rw,
                      input logic [1:0] sz, input logic sg, input logic [31:0] alu,
                      input logic [31:0] dm, input logic [4:0] dst);
    int unsigned a;
    logic mis;
    @(negedge clk);
    bus.stallInput = st; bus.flushInput = fl; bus.validInput = v; bus.memToRegInput = m2r;
    bus.regWriteInput = rw; bus.loadSizeInput = sz; bus.loadSignedInput = sg;
    bus.aluResultInput = alu; bus.dataMemoryInput = dm; bus.regWriteAddressInput = dst;
    a = alu % 4;
    mis = m2r && v && ((sz == 1 && a % 2 == 1) || (sz != 1 && sz != 2 && a != 0));
    if (fl) begin
      m.v = 0; m.we = 0; m.mis = 0; m.a = 0; m.d = 0;
    end else if (!st) begin
      m.v = v;
      m.mis = mis;
      m.we = v && rw && dst != 0 && !mis;
      m.a = dst;
      m.d = m2r ? load_val(sz, sg, a, dm) : alu;
`ifdef MEMORY_WRITEBACK_RETIRE_COUNTER_EN
      if (v) m.c = m.c + 1'b1;
`endif
    end
    q.push_back(m);
  endtask
  task automatic drain();
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    chk("drain", q.size(), 0);
    @(negedge clk);
  endtask
  task automatic model_reset();
    m.v = 0; m.we = 0; m.mis = 0; m.a = 0; m.d = 0; m.c = 0;
  endtask
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk_all("sb", e);
      end
    end
  end
  initial begin : stim
    logic [31:0] dm;
    bus.stallInput = 0; bus.flushInput = 0; bus.validInput = 0; bus.memToRegInput = 0;
    bus.regWriteInput = 0; bus.loadSizeInput = 0; bus.loadSignedInput = 0;
    bus.aluResultInput = 0; bus.dataMemoryInput = 0; bus.regWriteAddressInput = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_all("reset", m);
    @(negedge clk);
    reset = 1;
    step(0, 0, 1, 0, 1, 0, 0, 32'h1234_5678, 32'h0, 5'd5);
    dm = 32'h80FF_7F01;
    step(0, 0, 1, 1, 1, 2'b10, 1, 32'h3, dm, 5'd6);
    step(0, 0, 1, 1, 1, 2'b10, 0, 32'h1, dm, 5'd7);
    step(0, 0, 1, 1, 1, 2'b01, 1, 32'h2, dm, 5'd8);
    step(0, 0, 1, 1, 1, 2'b01, 0, 32'h0, dm, 5'd9);
    step(0, 0, 1, 1, 1, 2'b00, 0, 32'h2, dm, 5'd10);
    step(0, 0, 1, 1, 1, 2'b01, 0, 32'h1, dm, 5'd11);
    step(0, 0, 1, 1, 1, 2'b11, 1, 32'h0, dm, 5'd12);
    step(0, 0, 1, 0, 1, 0, 0, 32'hDEAD_BEEF, dm, 5'd0);
    step(0, 0, 1, 0, 1, 0, 0, 32'hAAAA_5555, 0, 5'd17);
    repeat (3) step(1, 0, 1, 0, 1, 0, 0, 32'h5555_AAAA, 0, 5'd18);
    step(1, 1, 1, 0, 1, 0, 0, 32'h5555_AAAA, 0, 5'd18);
    repeat (10) step(0, 0, 1, 0, 1, 0, 0, $urandom, 0, 5'($urandom));
    repeat (2) step(1, 0, 1, 0, 1, 0, 0, $urandom, 0, 5'd3);
    step(0, 1, 1, 0, 1, 0, 0, $urandom, 0, 5'd3);
    step(0, 0, 0, 0, 1, 0, 0, $urandom, 0, 5'd3);
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0, 1'($urandom), 1'($urandom),
           1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom, 5'($urandom));
    // stall then drop reset mid-cycle: held instruction must vanish at once
    step(0, 0, 1, 0, 1, 0, 0, 32'hCAFE_F00D, 0, 5'd9);
    step(1, 0, 1, 0, 1, 0, 0, 32'h0, 0, 5'd1);
    drain();
    @(posedge clk);
    #3;
    reset = 0;
    #1;
    model_reset();
    chk_all("async", m);
    @(negedge clk);
    chk_all("hold_rst", m);
    reset = 1;
    repeat (16) step(0, 0, 1, 0, 1, 0, 0, $urandom, 0, 5'($urandom));
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/memory_writeback.md
# memory_writeback

MEM/WB pipeline register plus writeback stage of the MIPS pipeline. It sits directly downstream of the memory stage. It registers that stage's outputs: control bits, ALU result, data-memory read word and destination register. It extracts and extends sub-word load data and selects the writeback value. It produces a qualified register-file write, plus an optional retired-instruction counter.

## Interface
Parameters:
- COUNT_WIDTH, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- stallInput  in  1  hold all registered state this cycle.
- flushInput  in  1  load a bubble (validOutput=0) this cycle.
- validInput  in  1  the memory stage holds a real instruction.
- memToRegInput  in  1  writeback selects load data (1) or ALU result (0).
- regWriteInput  in  1  instruction writes the register file.
- loadSizeInput  in  2  00 word, 01 halfword, 10 byte; 11 treated as word.
- loadSignedInput  in  1  sign-extend sub-word loads (1) or zero-extend (0).
- aluResultInput  in  32  ALU result; the low 2 bits are the byte address for loads.
- dataMemoryInput  in  32  raw word read from data memory.
- regWriteAddressInput  in  5  destination register.
- validOutput  out  1  registered valid.
- regWriteOutput  out  1  qualified register-file write enable.
- regWriteAddressOutput  out  5  registered destination.
- regWriteDataOutput  out  32  registered writeback data.
- misalignedOutput  out  1  registered misaligned-load flag.
- retiredCountOutput  out  COUNT_WIDTH  retired-instruction count.

## Operation
- Registered state: valid, destination, writeback data, misaligned flag and a qualified write bit.
- Each edge applies exactly one action, in this priority order:
  - reset low: every output 0, counter 0.
  - flush: valid, write bit and misaligned flag cleared. Data and destination are also loaded with 0.
  - stall: everything held.
  - otherwise: capture new inputs.
- Byte lanes are little-endian. a = aluResultInput[1:0].
  - Byte load: the byte is dataMemoryInput[8a+7:8a].
  - Halfword load: the halfword is dataMemoryInput[16·a[1]+15:16·a[1]].
  - Word load: the whole word.
- Extension: the selected byte or halfword is sign- or zero-extended to 32 bits per loadSignedInput.
- Writeback data: the extended load value when memToRegInput=1, else aluResultInput.
- Misaligned: memToRegInput=1 and validInput=1, with either:
  - a halfword load and a[0]=1, or
  - a word (or size 11) load and a≠00.
- Qualified write = validInput & regWriteInput & (regWriteAddressInput≠0) & !misaligned.
- Writes to register $0 are never issued.
- A misaligned load still captures its data and destination, and validOutput=1. Only regWriteOutput is suppressed.
- regWriteOutput, regWriteAddressOutput and regWriteDataOutput also serve as the forwarding source for the execute stage.

## Timing
- Latency: 1 cycle. Inputs sampled at edge N appear on the outputs after edge N and hold until the next capture.
- Reset is asynchronous. Outputs go to 0 immediately on the falling reset edge and stay 0 while reset is low.
- The first capture happens on the first rising clk edge after reset is released.
- Flush and stall in the same cycle: flush wins, giving a bubble.
- Stall holds outputs indefinitely. The memory stage must hold its inputs; this block does not buffer them.
- Reset asserted mid-stall discards the held instruction.
- The counter increments on an edge only when capturing (no reset, flush or stall) with validInput=1. Misaligned instructions count.
- The counter wraps from all-ones to 0 with no flag.

## Configuration
- Macro: MEMORY_WRITEBACK_RETIRE_COUNTER_EN.
- Defined: the COUNT_WIDTH counter described above drives retiredCountOutput.
- Undefined: no counter flops are built, and retiredCountOutput is tied to constant 0.
- All other behaviour is identical with and without the macro.

## Test plan
- Reset and first capture:
  - Stimulus: reset low mid-cycle, then released.
  - Response: all outputs 0 asynchronously.
  - Stimulus: capture valid=1, regWrite=1, memToReg=0, alu=0x1234_5678, dest=5.
  - Response: next cycle data=0x1234_5678, addr=5, regWriteOutput=1.
- Sub-word loads:
  - Setup: dataMemoryInput=0x80FF_7F01, memToReg=1.
  - Signed byte, a=3 → 0xFFFF_FF80. Unsigned byte, a=1 → 0x0000_007F.
  - Signed halfword, a=2 → 0xFFFF_80FF. Unsigned halfword, a=0 → 0x0000_7F01.
- Misaligned and $0 writes:
  - Word load at a=2 → misalignedOutput=1, validOutput=1, regWriteOutput=0.
  - Halfword load at a=1 → the same.
  - Write with dest=0 → regWriteOutput=0.
- Stall, then flush+stall:
  - Capture value A, then stall 3 cycles with new inputs B → outputs hold A.
  - Then assert flush and stall together → validOutput=0, regWriteOutput=0, data=0.
- Retired-instruction counter (macro defined):
  - 10 valid captures, 2 stalled cycles, 1 flush, 1 valid=0 capture → count=10.
  - Preload by running 2^COUNT_WIDTH valid captures with COUNT_WIDTH=4: 16 valid captures → count wraps to 0.
  - Macro undefined → the same stimulus gives constant 0.
